// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM encoding and data width
// for the single-outstanding AXI-Lite initiator.
package axi_lite_pkg;

    localparam int unsigned C_AXI_DATA_WIDTH = 32;
    localparam int unsigned C_AXI_STRB_WIDTH = C_AXI_DATA_WIDTH / 8;
    localparam int unsigned C_STATE_WIDTH    = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [C_STATE_WIDTH-1:0] ST_IDLE    = 3'd0;
    localparam logic [C_STATE_WIDTH-1:0] ST_WR_REQ  = 3'd1;
    localparam logic [C_STATE_WIDTH-1:0] ST_WR_RESP = 3'd2;
    localparam logic [C_STATE_WIDTH-1:0] ST_RD_REQ  = 3'd3;
    localparam logic [C_STATE_WIDTH-1:0] ST_RD_RESP = 3'd4;
    localparam logic [C_STATE_WIDTH-1:0] ST_DONE    = 3'd5;

    typedef enum logic [C_STATE_WIDTH-1:0] {
        IDLE    = ST_IDLE,
        WR_REQ  = ST_WR_REQ,
        WR_RESP = ST_WR_RESP,
        RD_REQ  = ST_RD_REQ,
        RD_RESP = ST_RD_RESP,
        DONE    = ST_DONE
    } state_t;

    // EXOKAY is not meaningful for AXI-Lite, so anything but OKAY is an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_master_if.sv
// Single-outstanding AXI4-Lite initiator bridging a core valid/ready request
// port onto AXI-Lite; misaligned requests complete locally with an error.
module axi_lite_master_if
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = C_AXI_DATA_WIDTH
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESETN,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    output logic                    resp_err,
    output logic [DATA_WIDTH-1:0]   resp_rdata,

    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_wstrb;
    logic                    r_wr;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_resp_valid;
    logic                    r_resp_err;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_accept;
    logic                    w_misaligned;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_aw_complete;
    logic                    w_w_complete;

    assign w_accept      = req_valid && (r_state == IDLE);
    assign w_misaligned  = (req_addr[1:0] != 2'b00);
    assign w_aw_hs       = r_awvalid && M_AXI_AWREADY;
    assign w_w_hs        = r_wvalid && M_AXI_WREADY;
    assign w_aw_complete = r_aw_done || w_aw_hs;
    assign w_w_complete  = r_w_done || w_w_hs;

    // Transaction FSM; every bus-facing control is a register updated here.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_wr         <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_wstrb   <= req_wstrb;
                        r_wr      <= req_wr;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (w_misaligned) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_state      <= DONE;
                        end else if (req_wr) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_REQ;
                        end
                    end
                end

                // AW and W retire independently; leave once both have.
                WR_REQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_complete && w_w_complete) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= resp_is_err(M_AXI_BRESP);
                        r_state      <= DONE;
                    end
                end

                RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        r_rready     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= resp_is_err(M_AXI_RRESP);
                        if (!r_wr) begin
                            r_rdata <= M_AXI_RDATA;
                        end
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end

                default: begin
                    r_awvalid    <= 1'b0;
                    r_wvalid     <= 1'b0;
                    r_bready     <= 1'b0;
                    r_arvalid    <= 1'b0;
                    r_rready     <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (r_state == IDLE);
    assign resp_valid    = r_resp_valid;
    assign resp_err      = r_resp_err;
    assign resp_rdata    = r_rdata;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_lite_master_if.sv
// Directed bench for axi_lite_master_if: the core port and the AXI slave side
// are both driven on the falling edge; outputs are sampled there too.
module tb_axi_lite_master_if;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int aw_cnt   = 0;
    int w_cnt    = 0;
    int b_cnt    = 0;
    int ar_cnt   = 0;
    int r_cnt    = 0;
    int rsp_cnt  = 0;

    axi_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .resp_valid    (resp_valid),
        .resp_err      (resp_err),
        .resp_rdata    (resp_rdata),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake and completion-pulse counters, sampled on the active edge.
    always @(posedge clk) begin
        if (awvalid && awready) aw_cnt++;
        if (wvalid && wready)   w_cnt++;
        if (bvalid && bready)   b_cnt++;
        if (arvalid && arready) ar_cnt++;
        if (rvalid && rready)   r_cnt++;
        if (resp_valid)         rsp_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic test_reset();
        @(negedge clk);
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else pass_cnt++;
        chk_cnt++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) $display("FAIL reset_axi_ctrl: got %b want 00000", {awvalid, wvalid, bready, arvalid, rready}); else pass_cnt++;
        chk_cnt++; if ({resp_valid, resp_err} !== 2'b00) $display("FAIL reset_resp: got %b want 00", {resp_valid, resp_err}); else pass_cnt++;
        chk_cnt++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", resp_rdata); else pass_cnt++;
        chk_cnt++; if ({awaddr, wdata, wstrb} !== 68'h0) $display("FAIL reset_addr_data: got %h want 0", {awaddr, wdata, wstrb}); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready); else pass_cnt++;
    endtask

    task automatic test_write_basic();
        int aw0 = aw_cnt;
        int w0  = w_cnt;
        int b0  = b_cnt;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h1000; req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL wr_accept_ready: got %b want 1", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = 1'b0;
        chk_cnt++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL wr_valids_c1: got %b want 11", {awvalid, wvalid}); else pass_cnt++;
        chk_cnt++; if (awaddr !== 32'h1000) $display("FAIL wr_awaddr: got %h want 00001000", awaddr); else pass_cnt++;
        chk_cnt++; if ({wdata, wstrb} !== {32'hDEADBEEF, 4'hF}) $display("FAIL wr_wdata_wstrb: got %h/%h want deadbeef/f", wdata, wstrb); else pass_cnt++;
        chk_cnt++; if (req_ready !== 1'b0) $display("FAIL wr_busy_ready: got %b want 0", req_ready); else pass_cnt++;
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        chk_cnt++; if ({awvalid, wvalid, bready} !== 3'b001) $display("FAIL wr_c2_ctrl: got %b want 001", {awvalid, wvalid, bready}); else pass_cnt++;
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        chk_cnt++; if ({resp_valid, resp_err} !== 2'b10) $display("FAIL wr_resp_c3: got %b want 10", {resp_valid, resp_err}); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL wr_c4_idle: got %b want 01", {resp_valid, req_ready}); else pass_cnt++;
        chk_cnt++; if ({aw_cnt - aw0, w_cnt - w0, b_cnt - b0} !== {32'd1, 32'd1, 32'd1}) $display("FAIL wr_hs_counts: got aw=%0d w=%0d b=%0d want 1/1/1", aw_cnt - aw0, w_cnt - w0, b_cnt - b0); else pass_cnt++;
    endtask

    task automatic test_w_before_aw();
        int b0 = b_cnt;
        int aw0 = aw_cnt;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0000_1A0C; req_wdata = 32'h0102_0304; req_wstrb = 4'h6;
        @(negedge clk);
        req_valid = 1'b0;
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        chk_cnt++; if ({awvalid, wvalid} !== 2'b10) $display("FAIL wfirst_c2_valids: got %b want 10", {awvalid, wvalid}); else pass_cnt++;
        bvalid = 1'b1; bresp = 2'b10;
        @(negedge clk);
        chk_cnt++; if ({awvalid, awaddr} !== {1'b1, 32'h0000_1A0C}) $display("FAIL wfirst_aw_held: got %b/%h want 1/00001a0c", awvalid, awaddr); else pass_cnt++;
        chk_cnt++; if ({bready, resp_valid} !== 2'b00) $display("FAIL wfirst_early_b: got %b want 00", {bready, resp_valid}); else pass_cnt++;
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        chk_cnt++; if ({awvalid, wvalid, bready} !== 3'b001) $display("FAIL wfirst_c4_ctrl: got %b want 001", {awvalid, wvalid, bready}); else pass_cnt++;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        chk_cnt++; if ({resp_valid, resp_err} !== 2'b11) $display("FAIL wfirst_resp_slverr: got %b want 11", {resp_valid, resp_err}); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({b_cnt - b0, aw_cnt - aw0} !== {32'd1, 32'd1}) $display("FAIL wfirst_counts: got b=%0d aw=%0d want 1/1", b_cnt - b0, aw_cnt - aw0); else pass_cnt++;
    endtask

    task automatic test_read_wait();
        int rsp0 = rsp_cnt;
        int ar0 = ar_cnt;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h2004;
        @(negedge clk);
        req_valid = 1'b0;
        chk_cnt++; if ({arvalid, araddr, awvalid} !== {1'b1, 32'h2004, 1'b0}) $display("FAIL rd_c1_ar: got %b/%h/%b want 1/00002004/0", arvalid, araddr, awvalid); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({arvalid, araddr} !== {1'b1, 32'h2004}) $display("FAIL rd_ar_held: got %b/%h want 1/00002004", arvalid, araddr); else pass_cnt++;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk_cnt++; if ({arvalid, rready} !== 2'b01) $display("FAIL rd_c3_ctrl: got %b want 01", {arvalid, rready}); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_cnt++; if ({rready, resp_valid} !== 2'b10) $display("FAIL rd_wait_%0d: got %b want 10", i, {rready, resp_valid}); else pass_cnt++;
        end
        rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
        @(negedge clk);
        rvalid = 1'b0; rdata = 32'h0;
        chk_cnt++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'h12345678}) $display("FAIL rd_resp: got %b%b/%h want 10/12345678", resp_valid, resp_err, resp_rdata); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({rsp_cnt - rsp0, ar_cnt - ar0} !== {32'd1, 32'd1}) $display("FAIL rd_single_pulse: got rsp=%0d ar=%0d want 1/1", rsp_cnt - rsp0, ar_cnt - ar0); else pass_cnt++;
    endtask

    task automatic test_read_decerr();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0000_3F00;
        @(negedge clk);
        req_valid = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFEF00D; rresp = 2'b11;
        @(negedge clk);
        rvalid = 1'b0; rresp = 2'b00;
        chk_cnt++; if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'hCAFEF00D}) $display("FAIL rd_decerr_resp: got %b%b/%h want 11/cafef00d", resp_valid, resp_err, resp_rdata); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        int aw0 = aw_cnt;
        int w0  = w_cnt;
        int ar0 = ar_cnt;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h1002; req_wdata = 32'hFFFF_0000; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        chk_cnt++; if ({resp_valid, resp_err} !== 2'b11) $display("FAIL mis_resp_c1: got %b want 11", {resp_valid, resp_err}); else pass_cnt++;
        chk_cnt++; if ({awvalid, wvalid, arvalid} !== 3'b000) $display("FAIL mis_no_valids: got %b want 000", {awvalid, wvalid, arvalid}); else pass_cnt++;
        chk_cnt++; if (resp_rdata !== 32'hCAFEF00D) $display("FAIL mis_rdata_kept: got %h want cafef00d", resp_rdata); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL mis_c2_idle: got %b want 01", {resp_valid, req_ready}); else pass_cnt++;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        chk_cnt++; if ({aw_cnt - aw0, w_cnt - w0, ar_cnt - ar0} !== {32'd0, 32'd0, 32'd0}) $display("FAIL mis_no_traffic: got aw=%0d w=%0d ar=%0d want 0/0/0", aw_cnt - aw0, w_cnt - w0, ar_cnt - ar0); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int rsp0 = rsp_cnt;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h3000; req_wdata = 32'hA5A5A5A5; req_wstrb = 4'h3;
        @(negedge clk);
        req_valid = 1'b0;
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        chk_cnt++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'hCAFEF00D}) $display("FAIL b2b_wr_resp: got %b%b/%h want 10/cafef00d", resp_valid, resp_err, resp_rdata); else pass_cnt++;
        chk_cnt++; if (req_ready !== 1'b0) $display("FAIL b2b_done_ready: got %b want 0", req_ready); else pass_cnt++;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h3004;
        @(negedge clk);
        chk_cnt++; if ({req_ready, resp_valid} !== 2'b10) $display("FAIL b2b_idle_accept: got %b want 10", {req_ready, resp_valid}); else pass_cnt++;
        @(negedge clk);
        req_valid = 1'b0;
        chk_cnt++; if ({arvalid, araddr} !== {1'b1, 32'h3004}) $display("FAIL b2b_rd_ar: got %b/%h want 1/00003004", arvalid, araddr); else pass_cnt++;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h55AA55AA; rresp = 2'b01;
        @(negedge clk);
        rvalid = 1'b0; rresp = 2'b00;
        chk_cnt++; if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'h55AA55AA}) $display("FAIL b2b_rd_exokay: got %b%b/%h want 11/55aa55aa", resp_valid, resp_err, resp_rdata); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (rsp_cnt - rsp0 !== 2) $display("FAIL b2b_pulses: got %0d want 2", rsp_cnt - rsp0); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int rsp0 = rsp_cnt;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h4000; req_wdata = 32'h11112222; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL rstmid_pending: got %b want 11", {awvalid, wvalid}); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if ({awvalid, wvalid} !== 2'b00) $display("FAIL rstmid_async_drop: got %b want 00", {awvalid, wvalid}); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++; if ({req_ready, resp_valid, resp_rdata} !== {2'b10, 32'h0}) $display("FAIL rstmid_release: got %b%b/%h want 10/00000000", req_ready, resp_valid, resp_rdata); else pass_cnt++;
        chk_cnt++; if (rsp_cnt - rsp0 !== 0) $display("FAIL rstmid_no_resp: got %0d want 0", rsp_cnt - rsp0); else pass_cnt++;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0040;
        @(negedge clk);
        req_valid = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0BADF00D; rresp = 2'b00;
        @(negedge clk);
        rvalid = 1'b0;
        chk_cnt++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'h0BADF00D}) $display("FAIL rstmid_next_txn: got %b%b/%h want 10/0badf00d", resp_valid, resp_err, resp_rdata); else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        repeat (2) @(negedge clk);
        test_reset();
        test_write_basic();
        test_w_before_aw();
        test_read_wait();
        test_read_decerr();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
